// File: rtl/vc_random_pkg.sv
// -----------------------------------------------------------------------------
// vc_random_pkg
//   Shared constants and types for the random-number checker:
//     - Tausworthe shift amounts (right 17, left 15)
//     - default 32-bit seed
//     - checker FSM state encoding
//     - taus_step(): one generator step, S -> S_next
// -----------------------------------------------------------------------------
package vc_random_pkg;

    localparam int unsigned TAUS_SHR          = 17;
    localparam int unsigned TAUS_SHL          = 15;
    localparam logic [31:0] TAUS_DEFAULT_SEED = 32'hdeadbeef;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chk_state_e;

    // t = (S >> 17) ^ S ; S_next = (t << 15) ^ t
    function automatic logic [31:0] taus_step(input logic [31:0] s);
        logic [31:0] t;
        t = (s >> TAUS_SHR) ^ s;
        return (t << TAUS_SHL) ^ t;
    endfunction

endpackage

// File: rtl/vc_tausworthe_state.sv
// -----------------------------------------------------------------------------
// vc_tausworthe_state
//   Owns the 32-bit expected-sequence state S and folds it down to an
//   p_out_nbits-wide expected message.
//   Ports:
//     clk        - clock, S updates on rising edge
//     reset      - async active-low, forces S = p_seed
//     i_load     - reload S with p_seed (takes priority over i_adv)
//     i_adv      - advance S by one Tausworthe step
//     o_expected - S[n-1:0] XOR each higher n-bit slice that fits in S[30:0]
// -----------------------------------------------------------------------------
module vc_tausworthe_state
    import vc_random_pkg::*;
#(
    parameter int          p_out_nbits = 4,
    parameter logic [31:0] p_seed      = TAUS_DEFAULT_SEED
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_load,
    input  logic                   i_adv,
    output logic [p_out_nbits-1:0] o_expected
);

    // Slice k covers S[k*n+n-1 : k*n]; keep slices whose top bit is <= 30,
    // so bit 31 never contributes.
    localparam int NSLICE = 31 / p_out_nbits;

    logic [31:0]                         r_state;
    logic [NSLICE-1:0][p_out_nbits-1:0]  w_slice;
    logic [p_out_nbits-1:0]              w_fold;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      r_state <= p_seed;
        else if (i_load) r_state <= p_seed;
        else if (i_adv)  r_state <= taus_step(r_state);
    end

    for (genvar k = 0; k < NSLICE; k++) begin : g_slice
        assign w_slice[k] = r_state[k*p_out_nbits +: p_out_nbits];
    end

    always_comb begin
        w_fold = '0;
        for (int k = 0; k < NSLICE; k++) w_fold = w_fold ^ w_slice[k];
    end

    assign o_expected = w_fold;

endmodule

// File: rtl/vc_random_num_checker.sv
// -----------------------------------------------------------------------------
// vc_random_num_checker
//   Checks a stream of messages against a Tausworthe-generated expected
//   sequence and reports run statistics.
//   Ports:
//     clk, reset      - clock / async active-low reset
//     start           - pulse: (re)start a run, samples num_msgs
//     num_msgs        - messages to check in this run
//     in_val/in_rdy   - valid/ready handshake for in_msg
//     in_msg          - message under test
//     done, pass      - run complete / complete with no mismatches
//     msg_count       - messages accepted this run
//     err_count       - mismatches this run (saturating)
//     first_err_idx   - msg_count at first mismatch, all-ones if none
// -----------------------------------------------------------------------------
module vc_random_num_checker
    import vc_random_pkg::*;
#(
    parameter int          p_out_nbits = 4,
    parameter logic [31:0] p_seed      = TAUS_DEFAULT_SEED,
    parameter int          p_cnt_nbits = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [p_cnt_nbits-1:0] num_msgs,
    input  logic                   in_val,
    output logic                   in_rdy,
    input  logic [p_out_nbits-1:0] in_msg,
    output logic                   done,
    output logic                   pass,
    output logic [p_cnt_nbits-1:0] msg_count,
    output logic [p_cnt_nbits-1:0] err_count,
    output logic [p_cnt_nbits-1:0] first_err_idx
);

    localparam logic [p_cnt_nbits-1:0] CNT_ONES = '1;
    localparam logic [p_cnt_nbits-1:0] CNT_ONE  = p_cnt_nbits'(1);

    chk_state_e             r_state;
    chk_state_e             w_state_nxt;
    logic [p_cnt_nbits-1:0] r_num;
    logic [p_cnt_nbits-1:0] r_msg_cnt;
    logic [p_cnt_nbits-1:0] r_err_cnt;
    logic [p_cnt_nbits-1:0] r_first_err;
    logic [p_cnt_nbits-1:0] w_err_nxt;
    logic                   r_done;
    logic                   r_pass;
    logic [p_out_nbits-1:0] w_expected;
    logic                   w_xfer;
    logic                   w_mismatch;
    logic                   w_last;

    // start wins over a coincident handshake: that beat is dropped entirely
    assign w_xfer     = in_val && in_rdy && !start;
    assign w_mismatch = w_xfer && (in_msg != w_expected);
    assign w_last     = w_xfer && ((r_msg_cnt + CNT_ONE) == r_num);

    vc_tausworthe_state #(
        .p_out_nbits (p_out_nbits),
        .p_seed      (p_seed)
    ) u_state (
        .clk        (clk),
        .reset      (reset),
        .i_load     (start),
        .i_adv      (w_xfer),
        .o_expected (w_expected)
    );

    // ---- FSM: state register ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // ---- FSM: next state ----
    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = (num_msgs == '0) ? ST_DONE : ST_RUN;
        end else begin
            case (r_state)
                ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // ---- FSM: outputs ----
    always_comb begin
        in_rdy = (r_state == ST_RUN);
    end

    // Next error count is needed up front so pass can be registered in the
    // same cycle that DONE is entered.
    always_comb begin
        w_err_nxt = r_err_cnt;
        if (start)                                  w_err_nxt = '0;
        else if (w_mismatch && r_err_cnt != CNT_ONES) w_err_nxt = r_err_cnt + CNT_ONE;
    end

    // ---- counters and registered status ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_num       <= '0;
            r_msg_cnt   <= '0;
            r_err_cnt   <= '0;
            r_first_err <= CNT_ONES;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            r_err_cnt <= w_err_nxt;
            if (start) begin
                r_num       <= num_msgs;
                r_msg_cnt   <= '0;
                r_first_err <= CNT_ONES;
            end else if (w_xfer) begin
                r_msg_cnt <= r_msg_cnt + CNT_ONE;
                if (w_mismatch && r_first_err == CNT_ONES) r_first_err <= r_msg_cnt;
            end
            r_done <= (w_state_nxt == ST_DONE);
            r_pass <= (w_state_nxt == ST_DONE) && (w_err_nxt == '0);
        end
    end

    assign done          = r_done;
    assign pass          = r_pass;
    assign msg_count     = r_msg_cnt;
    assign err_count     = r_err_cnt;
    assign first_err_idx = r_first_err;

endmodule

// File: tb/tb_vc_random_num_checker.sv
// -----------------------------------------------------------------------------
// tb_vc_random_num_checker
//   Stimulus pushes the expected end-of-run summary into a queue when a run
//   is started; the monitor pops and compares on every rising edge of done.
// -----------------------------------------------------------------------------
module tb_vc_random_num_checker;

    localparam int          N    = 4;
    localparam int          C    = 16;
    localparam logic [31:0] SEED = 32'hdeadbeef;

    typedef struct {
        logic         pass;
        logic [C-1:0] msg;
        logic [C-1:0] err;
        logic [C-1:0] first;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         start;
    logic [C-1:0] num_msgs;
    logic         in_val;
    logic         in_rdy;
    logic [N-1:0] in_msg;
    logic         done;
    logic         pass;
    logic [C-1:0] msg_count;
    logic [C-1:0] err_count;
    logic [C-1:0] first_err_idx;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];
    logic prev_done = 1'b0;

    vc_random_num_checker #(
        .p_out_nbits (N),
        .p_seed      (SEED),
        .p_cnt_nbits (C)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .num_msgs      (num_msgs),
        .in_val        (in_val),
        .in_rdy        (in_rdy),
        .in_msg        (in_msg),
        .done          (done),
        .pass          (pass),
        .msg_count     (msg_count),
        .err_count     (err_count),
        .first_err_idx (first_err_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Independent reference: per output bit, XOR the same bit position of
    // every n-bit slice lying wholly within S[30:0].
    function automatic logic [N-1:0] model_exp(input logic [31:0] s);
        logic [N-1:0] r;
        r = '0;
        for (int b = 0; b < N; b++)
            for (int k = 0; k * N + N - 1 <= 30; k++)
                r[b] = r[b] ^ s[k*N + b];
        return r;
    endfunction

    function automatic logic [31:0] model_step(input logic [31:0] s);
        logic [31:0] t;
        t = s ^ {17'd0, s[31:17]};
        return t ^ {t[16:0], 15'd0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [C-1:0] n);
        start    = 1'b1;
        num_msgs = n;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [N-1:0] m, input int gap);
        int w;
        in_val = 1'b0;
        repeat (gap) tick();
        in_val = 1'b1;
        in_msg = m;
        w = 0;
        while (!in_rdy && w < 20) begin tick(); w++; end
        if (!in_rdy) check("send_timeout", 32'(in_rdy), 32'd1);
        else         tick();
        in_val = 1'b0;
    endtask

    // Send n messages from the seed sequence; index bad (if < n) is corrupted.
    task automatic send_seq(input int n, input int bad, input bit gaps);
        logic [31:0] s;
        logic [N-1:0] m;
        s = SEED;
        for (int i = 0; i < n; i++) begin
            m = model_exp(s);
            if (i == bad) m = m ^ 4'h1;
            send(m, gaps ? int'($urandom_range(0, 3)) : 0);
            s = model_step(s);
        end
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        while (!done && w < 50) begin tick(); w++; end
        check("wait_done", 32'(done), 32'd1);
    endtask

    task automatic push(input logic p, input logic [C-1:0] m, input logic [C-1:0] e,
                        input logic [C-1:0] f);
        exp_t x;
        x.pass = p; x.msg = m; x.err = e; x.first = f;
        sb_q.push_back(x);
    endtask

    // Monitor: end-of-run summary compared when done rises
    always @(negedge clk) begin
        exp_t x;
        if (done && !prev_done) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                x = sb_q.pop_front();
                check("run_pass",      32'(pass),          32'(x.pass));
                check("run_msg_count", 32'(msg_count),     32'(x.msg));
                check("run_err_count", 32'(err_count),     32'(x.err));
                check("run_first_err", 32'(first_err_idx), 32'(x.first));
            end
        end
        prev_done = done;
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        num_msgs = '0;
        in_val   = 1'b0;
        in_msg   = '0;
        #1 reset = 1'b0;
        #2;
        check("rst_in_rdy",    32'(in_rdy),        32'd0);
        check("rst_done",      32'(done),          32'd0);
        check("rst_pass",      32'(pass),          32'd0);
        check("rst_msg_count", 32'(msg_count),     32'd0);
        check("rst_err_count", 32'(err_count),     32'd0);
        check("rst_first_err", 32'(first_err_idx), 32'hffff);
        tick();
        reset = 1'b1;
        tick();

        // num_msgs = 0: straight to DONE, never ready
        push(1'b1, 16'd0, 16'd0, 16'hffff);
        check("zero_rdy_before", 32'(in_rdy), 32'd0);
        start_run(16'd0);
        check("zero_done_next", 32'(done),   32'd1);
        check("zero_rdy_after", 32'(in_rdy), 32'd0);
        tick();
        check("zero_rdy_hold",  32'(in_rdy), 32'd0);

        // single message, hand-computed first value 4'hd
        push(1'b1, 16'd1, 16'd0, 16'hffff);
        start_run(16'd1);
        send(4'hd, 0);
        wait_done();

        // eight correct messages with random gaps
        push(1'b1, 16'd8, 16'd0, 16'hffff);
        start_run(16'd8);
        send_seq(8, -1, 1'b1);
        wait_done();

        // eight messages, index 3 corrupted
        push(1'b0, 16'd8, 16'd1, 16'd3);
        start_run(16'd8);
        send_seq(8, 3, 1'b0);
        wait_done();

        // restart mid-run after 5 transfers; coincident beat must be dropped
        start_run(16'd8);
        send_seq(5, -1, 1'b0);
        push(1'b1, 16'd4, 16'd0, 16'hffff);
        in_val = 1'b1;
        in_msg = 4'h0;
        start_run(16'd4);
        in_val = 1'b0;
        check("restart_msg_count", 32'(msg_count), 32'd0);
        send_seq(4, -1, 1'b0);
        wait_done();

        // async reset mid-run, between edges
        start_run(16'd8);
        send_seq(2, -1, 1'b0);
        check("mid_msg_count", 32'(msg_count), 32'd2);
        #2 reset = 1'b0;
        #1;
        check("arst_in_rdy",    32'(in_rdy),        32'd0);
        check("arst_done",      32'(done),          32'd0);
        check("arst_pass",      32'(pass),          32'd0);
        check("arst_msg_count", 32'(msg_count),     32'd0);
        check("arst_err_count", 32'(err_count),     32'd0);
        check("arst_first_err", 32'(first_err_idx), 32'hffff);
        tick();
        reset  = 1'b1;
        in_val = 1'b1;
        tick();
        tick();
        check("post_rst_idle_rdy", 32'(in_rdy),    32'd0);
        check("post_rst_idle_cnt", 32'(msg_count), 32'd0);
        in_val = 1'b0;
        tick();

        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
